// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-only slave that decodes 16-bit frames into the PWM control registers.
// Pins are oversampled in the clk domain; all outputs come straight from flops.
module spi_reg_bank #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_copi,
  input  logic       spi_ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_pulse
);

  localparam logic [6:0] NUM_REGS_L = 7'(NUM_REGS);
  localparam logic [4:0] FRAME_BITS = 5'd16;
  localparam logic [4:0] CNT_SAT    = 5'd17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic                   sclk_prev_q;
  logic                   ncs_prev_q;

  state_e      state_q;
  logic [4:0]  bit_cnt_q;
  logic [15:0] shreg_q;
  logic [7:0]  regs_q [0:4];
  logic        wr_pulse_q;

  logic sclk_s;
  logic copi_s;
  logic ncs_s;
  logic sclk_rise_s;
  logic ncs_rise_s;
  logic commit_ok_s;

  // Only a complete, write-flagged frame to an implemented address may update a register.
  function automatic logic frame_valid(input logic [4:0] cnt, input logic [15:0] frame);
    frame_valid = (cnt == FRAME_BITS) && frame[15] &&
                  (frame[14:8] < NUM_REGS_L) && (frame[14:8] < 7'd5);
  endfunction

  // Pin synchronizers; nCS resets high so an idle bus never looks like a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      copi_sync_q <= {SYNC_STAGES{1'b0}};
      ncs_sync_q  <= {SYNC_STAGES{1'b1}};
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], spi_copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi_ncs};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ncs_prev_q  <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  // Edge detection and commit decode.
  always_comb begin
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    copi_s      = copi_sync_q[SYNC_STAGES-1];
    ncs_s       = ncs_sync_q[SYNC_STAGES-1];
    sclk_rise_s = sclk_s & ~sclk_prev_q;
    ncs_rise_s  = ncs_s & ~ncs_prev_q;
    commit_ok_s = frame_valid(bit_cnt_q, shreg_q);
  end

  // Frame FSM, register file and write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 5'd0;
      shreg_q    <= 16'h0000;
      wr_pulse_q <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      wr_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!ncs_s) begin
            state_q   <= SHIFT;
            bit_cnt_q <= 5'd0;
            shreg_q   <= 16'h0000;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          // An sclk edge coinciding with the nCS rise is deliberately dropped.
          if (ncs_rise_s) begin
            state_q <= COMMIT;
          end else if (sclk_rise_s) begin
            shreg_q <= {shreg_q[14:0], copi_s};
            if (bit_cnt_q != CNT_SAT) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end else begin
              bit_cnt_q <= bit_cnt_q;
            end
          end else begin
            state_q <= SHIFT;
          end
        end
        COMMIT: begin
          if (commit_ok_s) begin
            case (shreg_q[10:8])
              3'd0:    regs_q[0] <= shreg_q[7:0];
              3'd1:    regs_q[1] <= shreg_q[7:0];
              3'd2:    regs_q[2] <= shreg_q[7:0];
              3'd3:    regs_q[3] <= shreg_q[7:0];
              3'd4:    regs_q[4] <= shreg_q[7:0];
              default: regs_q[0] <= regs_q[0];
            endcase
            wr_pulse_q <= 1'b1;
          end else begin
            wr_pulse_q <= 1'b0;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_pulse        = wr_pulse_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: a table of SPI frames with hand-computed register
// images, plus hand-written sequences for commit latency and mid-frame reset.
module tb_spi_reg_bank;

  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic       clk;
  logic       rst;
  logic       spi_sclk;
  logic       spi_copi;
  logic       spi_ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_pulse;

  int tests;
  int fails;
  int pulse_cnt;

  spi_reg_bank #(.SYNC_STAGES(SYNC), .NUM_REGS(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .spi_sclk        (spi_sclk),
    .spi_copi        (spi_copi),
    .spi_ncs         (spi_ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_pulse        (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // wr_pulse is a one-clock strobe, so one negedge sample per pulse.
  always @(negedge clk) begin
    if (wr_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  typedef struct {
    string       name;
    logic [15:0] frame;
    int          nbits;
    logic [39:0] exp_regs;
    int          exp_pulses;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [39:0] regs_now();
    return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
  endfunction

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Clocks out nbits starting at frame[15]; bits past 16 are zero.
  task automatic spi_bits(input logic [15:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_copi = (i < 16) ? frame[15-i] : 1'b0;
      wait_clk(HALF);
      spi_sclk = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
    end
    wait_clk(HALF);
  endtask

  task automatic send_frame(input logic [15:0] frame, input int nbits);
    spi_ncs = 1'b0;
    wait_clk(HALF);
    spi_bits(frame, nbits);
    spi_ncs = 1'b1;
    wait_clk(SYNC + 8);
  endtask

  initial begin
    int p0;
    int n;
    tests = 0;
    fails = 0;
    pulse_cnt = 0;

    vecs[0] = '{"wr_addr0",    16'h80F0, 16, 40'hF0_00_00_00_00, 1};
    vecs[1] = '{"wr_duty",     16'h8480, 16, 40'hF0_00_00_00_80, 1};
    vecs[2] = '{"read_frame",  16'h0455, 16, 40'hF0_00_00_00_80, 0};
    vecs[3] = '{"bad_addr5",   16'h85AA, 16, 40'hF0_00_00_00_80, 0};
    vecs[4] = '{"short15",     16'h81CC, 15, 40'hF0_00_00_00_80, 0};
    vecs[5] = '{"long17",      16'h81CC, 17, 40'hF0_00_00_00_80, 0};
    vecs[6] = '{"wr_addr1",    16'h81CC, 16, 40'hF0_CC_00_00_80, 1};
    vecs[7] = '{"wr_addr2",    16'h8255, 16, 40'hF0_CC_55_00_80, 1};
    vecs[8] = '{"bad_addr7f",  16'hFF12, 16, 40'hF0_CC_55_00_80, 0};
    vecs[9] = '{"wr_addr0_00", 16'h8000, 16, 40'h00_CC_55_00_80, 1};

    rst      = 1'b1;
    spi_sclk = 1'b0;
    spi_copi = 1'b0;
    spi_ncs  = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    check("reset_regs", regs_now(), 40'h0);
    check("reset_pulse", {39'h0, wr_pulse}, 40'h0);

    for (int v = 0; v < 10; v++) begin
      p0 = pulse_cnt;
      send_frame(vecs[v].frame, vecs[v].nbits);
      check({vecs[v].name, "_regs"}, regs_now(), vecs[v].exp_regs);
      check({vecs[v].name, "_pulses"}, 40'(pulse_cnt - p0), 40'(vecs[v].exp_pulses));
    end

    // Commit latency: strobe lands on the (SYNC+2)th edge counting the one that samples nCS high.
    p0 = pulse_cnt;
    spi_ncs = 1'b0;
    wait_clk(HALF);
    spi_bits(16'h8233, 16);
    spi_ncs = 1'b1;
    n = 0;
    while (n < 20 && wr_pulse !== 1'b1) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency_edges", 40'(n), 40'(SYNC + 2));
    check("latency_reg", regs_now(), 40'h00_CC_33_00_80);
    wait_clk(SYNC + 8);
    check("latency_pulses", 40'(pulse_cnt - p0), 40'd1);

    // Reset in the middle of 0x83FF; the tail bits must not complete a write of 0xFF.
    p0 = pulse_cnt;
    spi_ncs = 1'b0;
    wait_clk(HALF);
    spi_bits(16'h83FF, 8);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    spi_bits(16'hFF00, 8);
    spi_ncs = 1'b1;
    wait_clk(SYNC + 8);
    check("midrst_regs", regs_now(), 40'h0);
    check("midrst_pulses", 40'(pulse_cnt - p0), 40'd0);

    p0 = pulse_cnt;
    send_frame(16'h8311, 16);
    check("after_rst_regs", regs_now(), 40'h00_00_00_11_00);
    check("after_rst_pulses", 40'(pulse_cnt - p0), 40'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
